opamp_sar_ctrl: RTL and testbench
=================================

OPAMP_SAR_CTRL -- requirements
Module: opamp_sar_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8; result and DAC code width in bits (legal range 2..12).
REQ-002 SHALL provide parameter SETTLE_CYC, default 4; DAC/opamp settling cycles per trial bit (legal range 1..255).
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_ni, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port start_i, input, 1, conversion request; sampled only in IDLE.
REQ-006 SHALL have port abort_i, input, 1, cancels any conversion in progress.
REQ-007 SHALL have port cmp_i, input, 1, asynchronous opamp output; 0 means inp > inn (analog input above DAC level).
REQ-008 SHALL have port dac_code_o, output, WIDTH, trial code driven to the DAC feeding the opamp inn.
REQ-009 SHALL have port busy_o, output, 1, high in SETTLE and SAMPLE.
REQ-010 SHALL have port result_o, output, WIDTH, converted code; stable while valid_o is high.
REQ-011 SHALL have port valid_o, output, 1, result available.
REQ-012 SHALL have port ready_i, input, 1, consumer accepts result.

Function
REQ-013 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-014 In IDLE with start_i=1, the next state SHALL be SETTLE, with dac_code_o = 1<<(WIDTH-1), bit index = WIDTH-1, and the wait counter = SETTLE_CYC+1.
REQ-015 cmp_i SHALL pass through a 2-flop synchroniser before use; the SETTLE wait SHALL cover the synchroniser latency.
REQ-016 In SETTLE the counter SHALL decrement each cycle; at 0 the state SHALL advance to SAMPLE.
REQ-017 In SAMPLE (one cycle) the trial bit SHALL be kept if synchronised cmp = 0, otherwise cleared.
REQ-018 In the same SAMPLE cycle, if bit index > 0, the next lower bit SHALL be set in dac_code_o, the index decremented, the counter reloaded, and the state SHALL return to SETTLE.
REQ-019 In SAMPLE at bit index 0, result_o SHALL load the final code, valid_o SHALL assert next cycle, and the state SHALL become DONE.
REQ-020 Latency from the start_i accept edge to valid_o high SHALL be exactly WIDTH*(SETTLE_CYC+3)+1 cycles (57 at defaults).
REQ-021 In DONE, valid_o SHALL hold until a cycle with ready_i=1, then the state SHALL return to IDLE and valid_o SHALL deassert next cycle.
REQ-022 start_i SHALL be ignored outside IDLE, including in the same cycle as a completing handshake.
REQ-023 abort_i=1 in SETTLE or SAMPLE SHALL force IDLE next cycle, dac_code_o=0, with no valid_o and no change to result_o.
REQ-024 abort_i in IDLE or DONE SHALL have no effect.
REQ-025 If abort_i and the final SAMPLE coincide, abort SHALL win.
REQ-026 dac_code_o SHALL be 0 in IDLE and SHALL hold the final code in DONE.

Reset
REQ-027 While wb_rst_ni=0: state IDLE, dac_code_o=0, result_o=0, valid_o=0, busy_o=0, counter=0, synchroniser flops=1.
REQ-028 Reset assertion mid-conversion SHALL abandon the conversion immediately; the first start_i is accepted no earlier than the first edge after deassertion.

Structure
REQ-029 Package opamp_sar_pkg SHALL hold the state enum, SYNC_STAGES=2, and the default WIDTH/SETTLE_CYC constants.
REQ-030 Sub-module opamp_cmp_sync SHALL implement the 2-flop synchroniser (reset value 1); all other logic SHALL be in opamp_sar_ctrl.

Verification
Common stimulus for the scenarios below: comparator model cmp_i = (dac_code_o <= VIN) ? 0 : 1, with VIN an integer.
REQ-031 Defaults, VIN=0xA5, start pulse, ready_i=1 -> result_o=0xA5, valid_o high exactly 57 cycles after accept, single-cycle valid.
REQ-032 Boundaries: VIN=0x00 -> 0x00; VIN=0xFF -> 0xFF; the trial sequence for 0xFF is 0x80,0xC0,...,0xFF.
REQ-033 ready_i=0 for 10 cycles after valid_o -> valid_o and result_o held for all 10 cycles; start_i pulses in DONE are ignored.
REQ-034 abort_i at cycle 20 of a conversion -> IDLE next cycle, dac_code_o=0, no valid_o; a following conversion of VIN=0x3C yields 0x3C.
REQ-035 wb_rst_ni pulsed low mid-SETTLE -> all outputs 0 asynchronously; after deassertion, a fresh conversion of VIN=0x5A yields 0x5A.
REQ-036 WIDTH=4, SETTLE_CYC=1, VIN=0x9 -> result 0x9 with latency 17 cycles.

Source files
------------

// File: rtl/opamp_sar_pkg.sv
// Shared types and constants for the opamp-based SAR converter.
// State encoding, synchroniser depth and default sizing.
package opamp_sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } sar_state_e;

  localparam int SYNC_STAGES    = 2;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_SETTLE_CYC = 4;

endpackage

// File: rtl/opamp_cmp_sync.sv
// Multi-flop synchroniser for the asynchronous opamp output.
// Resets to 1 ("input below DAC level") so no bit is kept spuriously.
module opamp_cmp_sync
  import opamp_sar_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // shift the raw comparator level through the flop chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/opamp_sar_ctrl.sv
// Successive-approximation controller driving a DAC into an opamp
// comparator; one trial bit per SETTLE/SAMPLE round, MSB first.
module opamp_sar_ctrl
  import opamp_sar_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cmp_i,
  output logic [WIDTH-1:0] dac_code_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [BW-1:0] TOP_BIT = BW'(WIDTH - 1);
  localparam logic [8:0] RELOAD = 9'(SETTLE_CYC + 1);

  sar_state_e state_q, state_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [8:0] cnt_q, cnt_d;
  logic valid_q, valid_d;

  logic cmp_s;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] kept;

  opamp_cmp_sync u_sync (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .d_i    (cmp_i),
    .q_o    (cmp_s)
  );

  // trial bit mask and the code after judging the current trial
  assign mask = WIDTH'(1) << bit_q;
  assign kept = cmp_s ? (dac_q & ~mask) : dac_q;

  // state and datapath registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      dac_q   <= '0;
      res_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      res_q   <= res_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    res_d   = res_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SETTLE;
          dac_d   = MSB;
          bit_d   = TOP_BIT;
          cnt_d   = RELOAD;
        end
      end
      ST_SETTLE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          dac_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      ST_SAMPLE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          dac_d   = '0;
          cnt_d   = '0;
        end else if (bit_q != '0) begin
          state_d = ST_SETTLE;
          dac_d   = kept | (mask >> 1);
          bit_d   = bit_q - BW'(1);
          cnt_d   = RELOAD;
        end else begin
          state_d = ST_DONE;
          dac_d   = kept;
          res_d   = kept;
        end
      end
      ST_DONE: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
          dac_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dac_code_o = dac_q;
  assign result_o   = res_q;
  assign valid_o    = valid_q;
  assign busy_o     = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);

endmodule

// File: tb/tb_opamp_sar_ctrl.sv
// Self-checking bench for opamp_sar_ctrl with an ideal comparator model.
// Expected codes come from a plain binary-search reference.
module tb_opamp_sar_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start8 = 1'b0, abort8 = 1'b0, ready8 = 1'b0;
  logic [7:0] dac8, res8;
  logic busy8, valid8, cmp8;
  int vin8 = 0;

  logic start4 = 1'b0, ready4 = 1'b0;
  logic [3:0] dac4, res4;
  logic busy4, valid4, cmp4;
  int vin4 = 0;

  assign cmp8 = (int'(dac8) <= vin8) ? 1'b0 : 1'b1;
  assign cmp4 = (int'(dac4) <= vin4) ? 1'b0 : 1'b1;

  opamp_sar_ctrl dut8 (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .start_i    (start8),
    .abort_i    (abort8),
    .cmp_i      (cmp8),
    .dac_code_o (dac8),
    .busy_o     (busy8),
    .result_o   (res8),
    .valid_o    (valid8),
    .ready_i    (ready8)
  );

  opamp_sar_ctrl #(.WIDTH(4), .SETTLE_CYC(1)) dut4 (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .start_i    (start4),
    .abort_i    (1'b0),
    .cmp_i      (cmp4),
    .dac_code_o (dac4),
    .busy_o     (busy4),
    .result_o   (res4),
    .valid_o    (valid4),
    .ready_i    (ready4)
  );

  int checks = 0;
  int errors = 0;
  int last8 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full conversion on the 8-bit instance; dly = ready wait cycles.
  task automatic run8(input int vin, input int dly, input string nm);
    int n;
    int code;
    int t;
    int trials[$];
    int seen[$];
    bit ok;
    bit held;
    code = 0;
    for (int b = 7; b >= 0; b--) begin
      t = code + (1 << b);
      trials.push_back(t);
      if (t <= vin) code = t;
    end
    @(negedge clk);
    vin8 = vin;
    ready8 = (dly == 0);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    seen.push_back(int'(dac8));
    n = 0;
    while (!valid8 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (busy8 && int'(dac8) != seen[$]) seen.push_back(int'(dac8));
    end
    chk({nm, " latency"}, n, 8 * (4 + 3) + 1);
    chk({nm, " result"}, int'(res8), vin & 255);
    ok = (seen.size() == trials.size());
    if (ok) foreach (trials[i]) if (seen[i] != trials[i]) ok = 1'b0;
    chk({nm, " trials"}, int'(ok), 1);
    last8 = int'(res8);
    if (dly == 0) begin
      @(posedge clk); #1;
      chk({nm, " single valid"}, int'(valid8), 0);
    end else begin
      held = 1'b1;
      for (int i = 0; i < dly; i++) begin
        start8 = (i == 1);
        @(posedge clk); #1;
        if (!valid8 || int'(res8) != (vin & 255)) held = 1'b0;
      end
      chk({nm, " held"}, int'(held), 1);
      start8 = 1'b1;
      ready8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      ready8 = 1'b0;
      chk({nm, " valid drop"}, int'(valid8), 0);
      @(posedge clk); #1;
      chk({nm, " start ignored"}, int'(busy8), 0);
    end
    ready8 = 1'b0;
    chk({nm, " idle dac"}, int'(dac8), 0);
  endtask

  typedef struct {
    int vin;
    int dly;
    string nm;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;
    bit bad;
    tbl[0] = '{vin: 'hA5, dly: 0, nm: "a5"};
    tbl[1] = '{vin: 'h00, dly: 0, nm: "zero"};
    tbl[2] = '{vin: 'hFF, dly: 0, nm: "full"};
    tbl[3] = '{vin: 'h81, dly: 10, nm: "hold"};
    tbl[4] = '{vin: 'h7F, dly: 2, nm: "mid"};

    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", int'({dac8, res8, valid8, busy8}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run8(tbl[i].vin, tbl[i].dly, tbl[i].nm);

    for (int k = 0; k < 6; k++) begin
      run8(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), "rnd");
    end

    // abort twenty cycles into a conversion
    @(negedge clk);
    vin8 = 'h77;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    abort8 = 1'b1;
    @(posedge clk); #1;
    abort8 = 1'b0;
    chk("abort idle", int'({busy8, dac8}), 0);
    bad = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (valid8 || busy8) bad = 1'b1;
    end
    chk("abort no valid", int'(bad), 0);
    chk("abort result kept", int'(res8), last8);
    run8('h3C, 0, "post abort");

    // asynchronous reset mid-settle
    @(negedge clk);
    vin8 = 'h33;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset", int'({dac8, res8, valid8, busy8}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run8('h5A, 0, "post reset");

    // narrow instance
    @(negedge clk);
    vin4 = 9;
    ready4 = 1'b1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (!valid4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w4 latency", n, 4 * (1 + 3) + 1);
    chk("w4 result", int'(res4), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
